// File: rtl/dmem_ctrl_pkg.sv
// Shared types and sizing for the data-memory controller and its RAM bank.
// MEM_DEPTH is the codebase-wide data memory size in bytes.
package dmem_ctrl_pkg;

   localparam int MEM_DEPTH  = 256;
   localparam int IDX_W      = $clog2(MEM_DEPTH);
   localparam int DMEM_WORDS = MEM_DEPTH / 4;
   localparam int WORD_W     = IDX_W - 2;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_t;

   typedef logic [IDX_W-1:0]  dmem_idx_t;
   typedef logic [WORD_W-1:0] dmem_word_t;

   // Byte mask moved to its lane; any bit landing in [7:4] means the access crosses a word.
   function automatic logic [7:0] lane_mask(input logic [3:0] be, input logic [1:0] lane);
      return {4'b0000, be} << lane;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Retire-stage <-> data-memory controller bus: store commits, held loads, load responses.
interface dmem_ctrl_if;
   import dmem_ctrl_pkg::*;

   logic [3:0]  wr_en;
   logic        rd_en;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        valid;
   dmem_idx_t   valid_addr;
   logic [31:0] rd_data;
   logic        misaligned;

   modport master (
      output wr_en, rd_en, addr, wr_data,
      input  valid, valid_addr, rd_data, misaligned
   );

   modport slave (
      input  wr_en, rd_en, addr, wr_data,
      output valid, valid_addr, rd_data, misaligned
   );

endinterface

// File: rtl/dmem_ctrl_bank.sv
// Word-organised data RAM: one byte-lane-masked write port and one registered read port.
// Each lane is its own byte array so every lane infers a plain single-write RAM.
module dmem_bank
   import dmem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  we,
   input  dmem_word_t  waddr,
   input  logic [31:0] wdata,
   input  logic        re,
   input  dmem_word_t  raddr,
   output logic [31:0] rdata
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram_lane [DMEM_WORDS];
      logic [7:0] rdata_q;

      // Read and write share the edge; the read returns the pre-write contents.
      always_ff @(posedge clk) begin
         if (we[gi]) begin
            ram_lane[waddr] <= wdata[8*gi +: 8];
         end
         if (rst) begin
            rdata_q <= '0;
         end else if (re) begin
            rdata_q <= ram_lane[raddr];
         end
      end

      assign rdata[8*gi +: 8] = rdata_q;
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: commits retire-stage byte stores, sequences held loads through
// a fixed read latency and rejects stores whose lane-shifted mask crosses a word.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int RD_LATENCY = 2
)(
   input  logic        clk,
   input  logic        rst,
   dmem_ctrl_if.slave  bus
);

   localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

   dmem_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   dmem_idx_t   addr_q, addr_d;
   logic        valid_q, valid_d;
   dmem_idx_t   valid_addr_q, valid_addr_d;
   logic        mis_q, mis_d;

   logic [1:0]  st_lane;
   logic [7:0]  st_mask;
   logic        st_mis;
   logic [3:0]  bank_we;
   logic [31:0] bank_wdata;
   logic        rd_fire;
   logic [31:0] bank_rdata;
   logic        unused_addr_hi;

   // Upper address bits are don't-care: the memory aliases across the whole address space.
   assign unused_addr_hi = ^bus.addr[31:IDX_W];

   always_comb begin
      st_lane    = bus.addr[1:0];
      st_mask    = lane_mask(bus.wr_en, st_lane);
      st_mis     = |st_mask[7:4];
      bank_we    = (rst || st_mis) ? 4'b0000 : st_mask[3:0];
      bank_wdata = bus.wr_data << {st_lane, 3'b000};
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      valid_d      = 1'b0;
      valid_addr_d = valid_addr_q;
      mis_d        = st_mis;
      rd_fire      = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (bus.rd_en && !valid_q) begin
               state_d = DMEM_WAIT;
               addr_d  = bus.addr[IDX_W-1:0];
               cnt_d   = CNT_INIT;
            end
         end
         DMEM_WAIT: begin
            // A dropped request means retire flushed the load; abandon it silently.
            if (!bus.rd_en) begin
               state_d = DMEM_IDLE;
               cnt_d   = '0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rd_fire      = 1'b1;
               valid_d      = 1'b1;
               valid_addr_d = addr_q;
               state_d      = DMEM_RESP;
            end
         end
         DMEM_RESP: begin
            state_d = DMEM_IDLE;
         end
         default: begin
            state_d = DMEM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= DMEM_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         valid_q      <= 1'b0;
         valid_addr_q <= '0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         valid_addr_q <= valid_addr_d;
         mis_q        <= mis_d;
      end
   end

   dmem_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .waddr (bus.addr[IDX_W-1:2]),
      .wdata (bank_wdata),
      .re    (rd_fire && !rst),
      .raddr (addr_q[IDX_W-1:2]),
      .rdata (bank_rdata)
   );

   // The registered word is aligned using the lane captured with it, so rd_data is stable through RESP.
   assign bus.rd_data    = bank_rdata >> {valid_addr_q[1:0], 3'b000};
   assign bus.valid      = valid_q;
   assign bus.valid_addr = valid_addr_q;
   assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stimulus pushes expected responses, a negedge monitor checks them.
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;

   localparam int RD_LAT = 2;

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   int   mis_q[$];

   dmem_ctrl_if bus ();

   dmem_ctrl #(.RD_LATENCY(RD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, want, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: every valid or misaligned pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("load_tag", 32'(bus.valid_addr), 32'(e.tag));
               check("load_data", bus.rd_data, e.data);
               check("load_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (!rst && bus.misaligned === 1'b1) begin
            if (mis_q.size() == 0) begin
               check("unexpected_misaligned", 32'd1, 32'd0);
            end else begin
               check("misaligned_cycle", 32'(cyc), 32'(mis_q.pop_front()));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                           input bit expect_mis);
      bus.addr    = a;
      bus.wr_en   = be;
      bus.wr_data = d;
      if (expect_mis) mis_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      bus.wr_en = 4'b0000;
   endtask

   task automatic wait_valid_drop();
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) seen = 1;
      end
      if (!seen) check("valid_timeout", 32'd0, 32'd1);
      bus.rd_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] want);
      exp_t e;
      e.tag  = a[7:0];
      e.data = want;
      e.cyc  = cyc + 1 + RD_LAT;
      exp_q.push_back(e);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      wait_valid_drop();
   endtask

   initial begin
      exp_t e;
      bus.wr_en   = 4'b0000;
      bus.rd_en   = 1'b0;
      bus.addr    = '0;
      bus.wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(bus.valid), 32'd0);
      check("reset_valid_addr", 32'(bus.valid_addr), 32'd0);
      check("reset_rd_data", bus.rd_data, 32'd0);
      check("reset_misaligned", 32'(bus.misaligned), 32'd0);
      idle(1);

      // Word store and load, then a byte store into lane 3
      do_store(32'h10, 4'b1111, 32'hDEADBEEF, 0);
      do_load(32'h10, 32'hDEADBEEF);
      do_store(32'h13, 4'b0001, 32'h000000AA, 0);
      do_load(32'h13, 32'h000000AA);
      do_load(32'h10, 32'hAAADBEEF);
      do_load(32'h11, 32'h00AAADBE);

      // Word-crossing stores are rejected and leave the word intact
      do_store(32'h13, 4'b0011, 32'h00001234, 1);
      do_store(32'h12, 4'b1111, 32'h11223344, 1);
      idle(2);
      do_load(32'h10, 32'hAAADBEEF);
      do_load(32'h110, 32'hAAADBEEF);

      // Load aborted by dropping rd_en after one WAIT cycle
      do_store(32'h24, 4'b1111, 32'hCAFEF00D, 0);
      bus.addr  = 32'h20;
      bus.rd_en = 1'b1;
      idle(2);
      bus.rd_en = 1'b0;
      idle(4);
      do_load(32'h24, 32'hCAFEF00D);

      // Store on the acceptance edge is seen; store on the response edge is not
      do_store(32'h20, 4'b1111, 32'h11111111, 0);
      e.tag  = 8'h20;
      e.data = 32'h00000055;
      e.cyc  = cyc + 1 + RD_LAT;
      exp_q.push_back(e);
      bus.addr    = 32'h20;
      bus.rd_en   = 1'b1;
      bus.wr_en   = 4'b1111;
      bus.wr_data = 32'h00000055;
      idle(1);
      bus.wr_en = 4'b0000;
      idle(1);
      bus.wr_en   = 4'b1111;
      bus.wr_data = 32'h00000099;
      idle(1);
      bus.wr_en = 4'b0000;
      bus.rd_en = 1'b0;
      idle(3);
      do_load(32'h20, 32'h00000099);

      // Reset during WAIT drops the load and discards a store on the reset edge
      do_store(32'h30, 4'b1111, 32'h0BADF00D, 0);
      bus.addr  = 32'h2C;
      bus.rd_en = 1'b1;
      idle(1);
      rst         = 1'b1;
      bus.rd_en   = 1'b0;
      bus.addr    = 32'h30;
      bus.wr_en   = 4'b1111;
      bus.wr_data = 32'hFFFFFFFF;
      idle(1);
      bus.wr_en = 4'b0000;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_valid_addr", 32'(bus.valid_addr), 32'd0);
      check("rst_rd_data", bus.rd_data, 32'd0);
      idle(1);
      do_load(32'h30, 32'h0BADF00D);

      idle(4);
      check("pending_loads", 32'(exp_q.size()), 32'd0);
      check("pending_misaligned", 32'(mis_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
